// File: rtl/decoder13_route_ctrl.sv
// Route controller for a 1-to-2 decoder leaf: forwards flits through one output
// register and queues a per-flit select token taken from each packet's header.
module decoder13_route_ctrl #(
  parameter  int W        = 9,
  parameter  int ADDR_BIT = 0,
  parameter  int S_DEPTH  = 4,
  parameter  int CNT_W    = 16,
  localparam int PW       = $clog2(S_DEPTH),
  localparam int CW       = PW + 1
) (
  input  logic             CLK,
  input  logic             _RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             f_valid,
  input  logic             f_ready,
  output logic [W-1:0]     f_data,
  output logic             s_valid,
  input  logic             s_ready,
  output logic             s_data,
  output logic [CW-1:0]    s_count,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);

  typedef enum logic [0:0] {HEAD = 1'b0, BODY = 1'b1} state_e;

  state_e           state_q, state_d;
  logic             cur_sel_q, cur_sel_d;
  logic             f_valid_q, f_valid_d;
  logic [W-1:0]     f_data_q, f_data_d;
  logic             mem_q [S_DEPTH];
  logic             mem_d [S_DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [CNT_W-1:0] pkt_cnt1_q, pkt_cnt1_d;

  logic accept_s, pop_s, sel_s, tail_s;

  // Readiness uses only registered state, so a same-cycle pop never frees a slot.
  assign in_ready = (!f_valid_q || f_ready) && (count_q < CW'(S_DEPTH));
  assign accept_s = in_valid && in_ready;
  assign pop_s    = (count_q != {CW{1'b0}}) && s_ready;
  assign tail_s   = in_data[W-1];
  assign sel_s    = (state_q == HEAD) ? in_data[ADDR_BIT] : cur_sel_q;

  assign f_valid  = f_valid_q;
  assign f_data   = f_data_q;
  assign s_valid  = (count_q != {CW{1'b0}});
  assign s_data   = mem_q[rd_ptr_q];
  assign s_count  = count_q;
  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;

  always_comb begin
    state_d    = state_q;
    cur_sel_d  = cur_sel_q;
    f_valid_d  = f_valid_q;
    f_data_d   = f_data_q;
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    pkt_cnt0_d = pkt_cnt0_q;
    pkt_cnt1_d = pkt_cnt1_q;
    count_d    = count_q + CW'(accept_s) - CW'(pop_s);

    if (accept_s) begin
      case (state_q)
        HEAD: begin
          if (!tail_s) begin
            cur_sel_d = in_data[ADDR_BIT];
            state_d   = BODY;
          end else begin
            state_d   = HEAD;
          end
        end
        BODY: begin
          if (tail_s) begin
            state_d = HEAD;
          end else begin
            state_d = BODY;
          end
        end
        default: state_d = HEAD;
      endcase
      f_valid_d       = 1'b1;
      f_data_d        = in_data;
      mem_d[wr_ptr_q] = sel_s;
      wr_ptr_d        = wr_ptr_q + PW'(1);
      if (tail_s && sel_s) begin
        pkt_cnt1_d = pkt_cnt1_q + CNT_W'(1);
      end else if (tail_s) begin
        pkt_cnt0_d = pkt_cnt0_q + CNT_W'(1);
      end else begin
        pkt_cnt0_d = pkt_cnt0_q;
      end
    end else if (f_valid_q && f_ready) begin
      f_valid_d = 1'b0;
    end else begin
      f_valid_d = f_valid_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      state_q    <= HEAD;
      cur_sel_q  <= 1'b0;
      f_valid_q  <= 1'b0;
      f_data_q   <= {W{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      pkt_cnt0_q <= {CNT_W{1'b0}};
      pkt_cnt1_q <= {CNT_W{1'b0}};
      for (int i = 0; i < S_DEPTH; i++) begin
        mem_q[i] <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      cur_sel_q  <= cur_sel_d;
      f_valid_q  <= f_valid_d;
      f_data_q   <= f_data_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      pkt_cnt0_q <= pkt_cnt0_d;
      pkt_cnt1_q <= pkt_cnt1_d;
      for (int i = 0; i < S_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_decoder13_route_ctrl.sv
// Scoreboard bench for decoder13_route_ctrl: a packet model predicts flits,
// select tokens and packet counts; outputs are compared as they drain.
module tb_decoder13_route_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_data;
  logic        f_valid;
  logic        f_ready;
  logic [8:0]  f_data;
  logic        s_valid;
  logic        s_ready;
  logic        s_data;
  logic [2:0]  s_count;
  logic [15:0] pkt_cnt0;
  logic [15:0] pkt_cnt1;

  decoder13_route_ctrl dut (
    .CLK(clk), ._RESET(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .f_valid(f_valid), .f_ready(f_ready), .f_data(f_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_count(s_count), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;
  int acc_n   = 0;

  logic [8:0] stim_q [$];
  logic [8:0] exp_f_q [$];
  logic       exp_s_q [$];

  logic        m_head = 1'b1;
  logic        m_cur  = 1'b0;
  logic [15:0] m_cnt0 = 16'd0;
  logic [15:0] m_cnt1 = 16'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    in_valid = (stim_q.size() != 0);
    in_data  = (stim_q.size() != 0) ? stim_q[0] : 9'h000;
  endtask

  task automatic model_reset();
    stim_q.delete();
    exp_f_q.delete();
    exp_s_q.delete();
    m_head = 1'b1;
    m_cur  = 1'b0;
    m_cnt0 = 16'd0;
    m_cnt1 = 16'd0;
  endtask

  // One clock: score handshakes at the falling edge, then advance and re-drive.
  task automatic step();
    logic sel;
    @(negedge clk);
    if (rst_n) begin
      if (in_valid && in_ready) begin
        sel = m_head ? in_data[0] : m_cur;
        if (m_head && !in_data[8]) begin
          m_cur  = in_data[0];
          m_head = 1'b0;
        end else if (!m_head && in_data[8]) begin
          m_head = 1'b1;
        end
        if (in_data[8] && sel) m_cnt1 = m_cnt1 + 16'd1;
        else if (in_data[8]) m_cnt0 = m_cnt0 + 16'd1;
        exp_f_q.push_back(in_data);
        exp_s_q.push_back(sel);
        void'(stim_q.pop_front());
        acc_n++;
      end
      if (f_valid && f_ready) begin
        check("f_expected", 32'(exp_f_q.size() != 0), 32'd1);
        if (exp_f_q.size() != 0) check("f_data", 32'(f_data), 32'(exp_f_q.pop_front()));
      end
      if (s_valid && s_ready) begin
        check("s_expected", 32'(exp_s_q.size() != 0), 32'd1);
        if (exp_s_q.size() != 0) check("s_data", 32'(s_data), 32'(exp_s_q.pop_front()));
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((stim_q.size() != 0 || exp_f_q.size() != 0 || exp_s_q.size() != 0) && n < 60) begin
      step();
      n++;
    end
    check({tag, "_drain_timeout"}, 32'(n < 60), 32'd1);
    check({tag, "_cnt0"}, 32'(pkt_cnt0), 32'(m_cnt0));
    check({tag, "_cnt1"}, 32'(pkt_cnt1), 32'(m_cnt1));
  endtask

  int a0;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 9'h101;
    f_ready  = 1'b1;
    s_ready  = 1'b1;

    // Reset held with in_valid asserted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_f_valid", 32'(f_valid), 32'd0);
      check("rst_s_valid", 32'(s_valid), 32'd0);
      check("rst_s_count", 32'(s_count), 32'd0);
      check("rst_cnt", 32'({pkt_cnt1, pkt_cnt0}), 32'd0);
    end
    check("rst_f_data", 32'(f_data), 32'd0);
    check("rst_s_data", 32'(s_data), 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    drive();

    // Single-flit packets and one-cycle latency
    stim_q.push_back(9'h101);
    stim_q.push_back(9'h100);
    drive();
    step();
    check("single_lat_f0", 32'({f_valid, f_data}), 32'h301);
    check("single_lat_s0", 32'({s_valid, s_data}), 32'd3);
    step();
    check("single_lat_f1", 32'({f_valid, f_data}), 32'h300);
    check("single_lat_s1", 32'({s_valid, s_data}), 32'd2);
    drain("single");
    check("single_cnt1_is1", 32'(pkt_cnt1), 32'd1);
    check("single_cnt0_is1", 32'(pkt_cnt0), 32'd1);

    // Multi-flit packet counts only on its tail
    stim_q.push_back(9'h003);
    stim_q.push_back(9'h0F2);
    stim_q.push_back(9'h1F0);
    drive();
    step();
    step();
    check("multi_body_s", 32'(s_data), 32'd1);
    check("multi_no_cnt_yet", 32'(pkt_cnt1), 32'd1);
    step();
    check("multi_tail_s", 32'(s_data), 32'd1);
    check("multi_cnt1", 32'(pkt_cnt1), 32'd2);
    drain("multi");

    // Select FIFO full stalls input even with f_ready high
    s_ready = 1'b0;
    stim_q = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h106};
    drive();
    a0 = acc_n;
    for (int i = 0; i < 8; i++) step();
    check("sfull_accepted", 32'(acc_n - a0), 32'd4);
    check("sfull_s_count", 32'(s_count), 32'd4);
    check("sfull_in_ready", 32'(in_ready), 32'd0);
    check("sfull_head", 32'({s_valid, s_data}), 32'd3);
    s_ready = 1'b1;
    drain("sfull");
    check("sfull_cnt1", 32'(pkt_cnt1), 32'd3);

    // Flit backpressure: one accept, data held, then full rate
    f_ready = 1'b0;
    stim_q = '{9'h0A0, 9'h0A1, 9'h1A2};
    drive();
    a0 = acc_n;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fbp_hold", 32'({f_valid, f_data}), 32'h2A0);
    end
    check("fbp_accepted", 32'(acc_n - a0), 32'd1);
    check("fbp_in_ready", 32'(in_ready), 32'd0);
    f_ready = 1'b1;
    step();
    step();
    check("fbp_rate", 32'(acc_n - a0), 32'd3);
    drain("fbp");
    check("fbp_cnt0", 32'(pkt_cnt0), 32'd2);

    // Reset mid-packet discards queued tokens and partial packet
    s_ready = 1'b0;
    stim_q = '{9'h001, 9'h002, 9'h003};
    drive();
    step();
    step();
    rst_n = 1'b0;
    model_reset();
    drive();
    #1;
    check("mid_rst_s_count", 32'(s_count), 32'd0);
    check("mid_rst_s_valid", 32'(s_valid), 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    s_ready = 1'b1;
    @(posedge clk);
    #1;
    stim_q.push_back(9'h100);
    drive();
    step();
    check("mid_rst_sel", 32'({s_valid, s_data}), 32'd2);
    drain("mid_rst");
    check("mid_rst_cnt0", 32'(pkt_cnt0), 32'd1);
    check("mid_rst_cnt1", 32'(pkt_cnt1), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
